// File: rtl/bcd2bin_pkg.sv
// rtl/bcd2bin_pkg.sv - shared types and constants for the BCD-to-binary controller
//
// Holds the FSM state encoding, the digit/bit counts, the largest accepted
// operand and the operand validity check used by controlador_bcd2bin.
package bcd2bin_pkg;

  localparam int N_DIGITOS = 5;
  localparam int N_BITS    = 16;
  localparam int W_BCD     = 4 * N_DIGITOS;
  localparam int CNT_W     = 5;

  localparam logic [W_BCD-1:0] MAX_BCD = 20'h65535;

  typedef enum logic [2:0] {
    REPOSO,
    CARGA,
    DESPLAZA,
    CORRIGE,
    FIN
  } estado_t;

  // Once every digit is <= 9, BCD ordering matches plain unsigned ordering,
  // so the range check can be a straight magnitude compare.
  function automatic logic bcd_valido(input logic [W_BCD-1:0] v);
    logic ok;
    ok = (v <= MAX_BCD);
    for (int i = 0; i < N_DIGITOS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/controlador_bcd2bin_corrector.sv
// rtl/controlador_bcd2bin_corrector.sv - per-digit >=8 / subtract-3 correction slices
//
// Ports:
//   salida_reg   in  digit field fed back from the shift register
//   habilitar    in  high only in CORRIGE; forces all outputs to 0 otherwise
//   carga_a2     out per-digit reload enable (digit >= 8), bit N-1 = MS digit
//   entrada_reg2 out corrected digits (digit - 3, 4-bit wrap), 0 where not enabled
module corrector_digitos
  import bcd2bin_pkg::*;
#(
  parameter int N_DIG = N_DIGITOS
) (
  input  logic [4*N_DIG-1:0] salida_reg,
  input  logic               habilitar,
  output logic [N_DIG-1:0]   carga_a2,
  output logic [4*N_DIG-1:0] entrada_reg2
);

  for (genvar i = 0; i < N_DIG; i++) begin : g_slice
    logic [3:0] digito;
    logic       en;

    assign digito = salida_reg[4*i +: 4];
    // After a right shift a digit >= 8 means a bit of weight 10 entered it
    // as weight 8; removing 3 restores the decimal carry relationship.
    assign en     = habilitar && (digito >= 4'd8);

    assign carga_a2[i]           = en;
    assign entrada_reg2[4*i +: 4] = en ? (digito - 4'd3) : 4'd0;
  end

endmodule

// File: rtl/controlador_bcd2bin.sv
// rtl/controlador_bcd2bin.sv - sequencer for the 36-bit reverse double-dabble register
//
// Ports:
//   reloj, reset       clock and synchronous active-high reset
//   inicio, bcd_in     start request and 5-digit BCD operand (sampled in REPOSO)
//   salida_reg(2)      register digit / binary fields fed back
//   reset_carga        load strobe (CARGA)
//   desplazar          right-shift strobe (DESPLAZA)
//   carga_a2           per-digit reload enables (CORRIGE only)
//   entrada_reg1       latched operand
//   entrada_reg2       corrected digit field
//   binario, error     result and operand-rejected flag, valid with listo
//   listo              one-cycle done pulse (FIN)
//   ocupado            high outside REPOSO
module controlador_bcd2bin
  import bcd2bin_pkg::*;
#(
  parameter int N_DIGITOS = bcd2bin_pkg::N_DIGITOS,
  parameter int N_BITS    = bcd2bin_pkg::N_BITS
) (
  input  logic                   reloj,
  input  logic                   reset,
  input  logic                   inicio,
  input  logic [4*N_DIGITOS-1:0] bcd_in,
  input  logic [4*N_DIGITOS-1:0] salida_reg,
  input  logic [N_BITS-1:0]      salida_reg2,
  output logic                   reset_carga,
  output logic                   desplazar,
  output logic [N_DIGITOS-1:0]   carga_a2,
  output logic [4*N_DIGITOS-1:0] entrada_reg1,
  output logic [4*N_DIGITOS-1:0] entrada_reg2,
  output logic [N_BITS-1:0]      binario,
  output logic                   listo,
  output logic                   error,
  output logic                   ocupado
);

  localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(N_BITS);

  estado_t                estado;
  logic [CNT_W-1:0]       contador;
  logic [CNT_W-1:0]       contador_sig;
  logic [4*N_DIGITOS-1:0] operando;

  assign contador_sig = contador + 1'b1;
  assign entrada_reg1 = operando;

  corrector_digitos #(
    .N_DIG(N_DIGITOS)
  ) u_corrector (
    .salida_reg  (salida_reg),
    .habilitar   (estado == CORRIGE),
    .carga_a2    (carga_a2),
    .entrada_reg2(entrada_reg2)
  );

  // Strobes are registered together with the next state so they stay
  // stable for the whole cycle; the register samples them on the falling edge.
  always_ff @(posedge reloj) begin
    if (reset) begin
      estado      <= REPOSO;
      binario     <= '0;
      error       <= 1'b0;
      operando    <= '0;
      contador    <= '0;
      reset_carga <= 1'b0;
      desplazar   <= 1'b0;
      listo       <= 1'b0;
      ocupado     <= 1'b0;
    end else begin
      case (estado)
        REPOSO: begin
          if (inicio) begin
            operando <= bcd_in;
            ocupado  <= 1'b1;
            contador <= '0;
            if (bcd_valido(bcd_in)) begin
              error       <= 1'b0;
              reset_carga <= 1'b1;
              estado      <= CARGA;
            end else begin
              // Rejected operands skip the register entirely.
              error   <= 1'b1;
              binario <= '0;
              listo   <= 1'b1;
              estado  <= FIN;
            end
          end
        end
        CARGA: begin
          reset_carga <= 1'b0;
          desplazar   <= 1'b1;
          estado      <= DESPLAZA;
        end
        DESPLAZA: begin
          desplazar <= 1'b0;
          contador  <= contador_sig;
          if (contador_sig == ULTIMO) begin
            // The last shift landed on the falling edge just before this edge.
            binario <= salida_reg2;
            listo   <= 1'b1;
            estado  <= FIN;
          end else begin
            estado <= CORRIGE;
          end
        end
        CORRIGE: begin
          desplazar <= 1'b1;
          estado    <= DESPLAZA;
        end
        FIN: begin
          listo   <= 1'b0;
          ocupado <= 1'b0;
          estado  <= REPOSO;
        end
        default: begin
          reset_carga <= 1'b0;
          desplazar   <= 1'b0;
          listo       <= 1'b0;
          ocupado     <= 1'b0;
          estado      <= REPOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_bcd2bin.sv
// tb/tb_controlador_bcd2bin.sv - scoreboard bench for controlador_bcd2bin with register model
module tb_controlador_bcd2bin;

  logic        reloj;
  logic        reset;
  logic        inicio;
  logic [19:0] bcd_in;
  logic [19:0] salida_reg;
  logic [15:0] salida_reg2;
  logic        reset_carga;
  logic        desplazar;
  logic [4:0]  carga_a2;
  logic [19:0] entrada_reg1;
  logic [19:0] entrada_reg2;
  logic [15:0] binario;
  logic        listo;
  logic        error;
  logic        ocupado;

  controlador_bcd2bin dut (
    .reloj       (reloj),
    .reset       (reset),
    .inicio      (inicio),
    .bcd_in      (bcd_in),
    .salida_reg  (salida_reg),
    .salida_reg2 (salida_reg2),
    .reset_carga (reset_carga),
    .desplazar   (desplazar),
    .carga_a2    (carga_a2),
    .entrada_reg1(entrada_reg1),
    .entrada_reg2(entrada_reg2),
    .binario     (binario),
    .listo       (listo),
    .error       (error),
    .ocupado     (ocupado)
  );

  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  // 36-bit BCD-to-binary register, captures on the falling edge.
  logic [35:0] registro;
  initial registro = '0;
  always @(negedge reloj) begin
    if (reset_carga) registro = {entrada_reg1, 16'h0000};
    else if (desplazar) registro = registro >> 1;
    else begin
      for (int i = 0; i < 5; i++)
        if (carga_a2[i]) registro[16 + 4*i +: 4] = entrada_reg2[4*i +: 4];
    end
  end
  assign salida_reg  = registro[35:16];
  assign salida_reg2 = registro[15:0];

  typedef struct {
    logic [15:0] bin;
    bit          err;
    int          acc;
  } esperado_t;

  esperado_t q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_desp = 0;
  int n_carga = 0;

  always @(posedge reloj) cyc <= cyc + 1;

  // Reference: decimal value of the digits; invalid digit or out of 16-bit range -> error.
  function automatic void modelo(input logic [19:0] v, output logic [15:0] b, output bit e);
    int s;
    int d;
    s = 0;
    e = 0;
    for (int i = 4; i >= 0; i--) begin
      d = int'(v[4*i +: 4]);
      if (d > 9) e = 1;
      s = s * 10 + d;
    end
    if (s > 65535) e = 1;
    b = e ? 16'h0000 : s[15:0];
  endfunction

  task automatic check(input string nombre, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nombre, got, exp);
    end
  endtask

  // Monitor: pops an expectation on every listo.
  always @(negedge reloj) begin
    esperado_t e;
    if (!reset) begin
      if (desplazar) n_desp++;
      if (reset_carga) n_carga++;
      if (carga_a2 != 5'd0 && (!ocupado || desplazar || reset_carga || listo)) begin
        tests++;
        fails++;
        $display("FAIL carga_a2_outside_corrige: got %h expected 0", carga_a2);
      end
      if (listo) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_listo: got listo=1 expected no pending conversion");
        end else begin
          e = q.pop_front();
          check("binario", 32'(binario), 32'(e.bin));
          check("error", 32'(error), 32'(e.err));
          check("latency", 32'(cyc - e.acc), e.err ? 32'd0 : 32'd32);
          check("desplazar_pulses", 32'(n_desp), e.err ? 32'd0 : 32'd16);
          check("carga_pulses", 32'(n_carga), e.err ? 32'd0 : 32'd1);
        end
      end
    end
  end

  task automatic iniciar(input logic [19:0] v);
    int k;
    esperado_t e;
    k = 0;
    @(negedge reloj);
    while ((ocupado || reset) && k < 200) begin
      @(negedge reloj);
      k++;
    end
    if (k >= 200) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: got ocupado=%b expected 0", ocupado);
    end
    bcd_in = v;
    inicio = 1'b1;
    @(posedge reloj);
    #1;
    inicio = 1'b0;
    modelo(v, e.bin, e.err);
    e.acc = cyc;
    n_desp = 0;
    n_carga = 0;
    q.push_back(e);
  endtask

  task automatic esperar_fin();
    int k;
    k = 0;
    while ((q.size() != 0 || ocupado) && k < 200) begin
      @(negedge reloj);
      k++;
    end
    if (k >= 200) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got pending=%0d expected 0", q.size());
      q.delete();
    end
  endtask

  logic [19:0] v;

  initial begin
    reset = 1'b1;
    inicio = 1'b0;
    bcd_in = '0;
    repeat (3) @(posedge reloj);
    #1;
    reset = 1'b0;
    @(negedge reloj);
    check("reset_outputs",
          {1'b0, ocupado, listo, reset_carga, desplazar, error, carga_a2, binario},
          32'd0);

    iniciar(20'h00000); esperar_fin();
    iniciar(20'h12345); esperar_fin();
    iniciar(20'h65535); esperar_fin();
    iniciar(20'h65536); esperar_fin();
    iniciar(20'h1A000); esperar_fin();
    iniciar(20'h00099); esperar_fin();

    // Second start while busy must be ignored.
    iniciar(20'h00042);
    repeat (9) @(posedge reloj);
    #1;
    bcd_in = 20'h99999;
    inicio = 1'b1;
    @(posedge reloj);
    #1;
    inicio = 1'b0;
    check("operand_held_busy", 32'(entrada_reg1), 32'h00042);
    esperar_fin();

    // Reset in the middle of a conversion aborts it.
    iniciar(20'h54321);
    repeat (11) @(posedge reloj);
    #1;
    reset = 1'b1;
    q.delete();
    @(posedge reloj);
    #1;
    reset = 1'b0;
    check("abort_ctrl", {27'd0, ocupado, listo, reset_carga, desplazar, error}, 32'd0);
    check("abort_data", {11'd0, carga_a2, binario}, 32'd0);
    check("abort_operand", 32'(entrada_reg1 | entrada_reg2), 32'd0);
    iniciar(20'h00007); esperar_fin();

    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < 5; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 5) == 0) v[4*$urandom_range(0, 4) +: 4] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 4) == 0) v[19:16] = 4'($urandom_range(5, 7));
      iniciar(v);
      esperar_fin();
    end

    repeat (3) @(negedge reloj);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/controlador_bcd2bin.md
Name: controlador_bcd2bin

Overview:
Sequencer for the 36-bit BCD-to-binary shift register (five BCD digits in bits 35:16, 16-bit binary result in bits 15:0). It accepts a 5-digit BCD operand and drives the register's load, shift and per-digit reload controls to run reverse double-dabble. Each pass is a right shift followed by subtract-3 on every digit >= 8. It returns a 16-bit binary result with a done pulse. It sits between the calculator's operand/entry logic and the BCD-to-binary register, and is the only driver of that register's control inputs.

Parameters:
N_DIGITOS, 5, BCD digits handled; fixes the widths of carga_a2, entrada_reg1 and entrada_reg2.
N_BITS, 16, binary result width, which is also the number of right shifts per conversion.

Ports:
reloj  input  1  system clock; all controller state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
inicio  input  1  start request; sampled only in REPOSO.
bcd_in  input  20  operand, 5 BCD digits, MS digit in bits 19:16.
salida_reg  input  20  register bits 35:16 (digit field), fed back.
salida_reg2  input  16  register bits 15:0 (binary field), fed back.
reset_carga  output  1  register load strobe.
desplazar  output  1  register right-shift strobe.
carga_a2  output  5  per-digit reload enables; bit 4 = MS digit.
entrada_reg1  output  20  latched operand presented to the register.
entrada_reg2  output  20  corrected digit field (digit-3 where digit >= 8).
binario  output  16  conversion result.
listo  output  1  one-cycle done pulse.
error  output  1  operand rejected; valid while listo=1.
ocupado  output  1  high in every state except REPOSO.

Behaviour:
- Clock and reset: single clock `reloj`. Reset is synchronous and active-high.
- Reset values:
  - State goes to REPOSO.
  - binario=0, error=0, operand latch=0, shift counter=0.
  - All strobes low; listo=0; ocupado=0.
  - Reset mid-conversion aborts the conversion. The register is not cleared; the next load overwrites it.
- Timing relation to the register: the register captures on the falling edge of `reloj`.
  - Controls are a Moore decode of the state, so they are stable for the whole cycle.
  - Register updates appear on salida_reg/salida_reg2 at the next rising edge.
- States and outputs:
  - REPOSO: all strobes 0.
  - CARGA: reset_carga=1.
  - DESPLAZA: desplazar=1.
  - CORRIGE: carga_a2 and entrada_reg2 are driven combinationally from salida_reg.
  - FIN: listo=1.
  - carga_a2=0 in every state except CORRIGE.
- Transitions:
  - REPOSO, inicio=1, operand valid: latch bcd_in, clear error, go to CARGA.
  - REPOSO, inicio=1, operand invalid: latch bcd_in, set error, set binario=0, go to FIN. listo rises in the cycle after the accept edge.
  - CARGA -> DESPLAZA.
  - DESPLAZA: increment counter. If the new count is 16, capture salida_reg2 into binario and go to FIN; otherwise go to CORRIGE. No correction follows the 16th shift.
  - CORRIGE -> DESPLAZA.
  - FIN -> REPOSO. binario and error hold until the next accept or reset.
- Operand validity:
  - Every digit must be <= 9.
  - The operand must be <= 20'h65535 (BCD comparison).
  - Any violation sets error=1.
- Correction rule, per digit i: carga_a2[i] = (salida_reg digit i >= 8). entrada_reg2 digit i = salida_reg digit i - 3 (4-bit, no borrow) when the enable is set, else 0.
- Latency: accept edge, then CARGA (1 cycle), then 15 DESPLAZA/CORRIGE pairs and a final DESPLAZA (31 cycles). listo is high in cycle 33 after the accept edge, with binario valid in that same cycle.
- Busy handling: inicio is ignored while ocupado=1. inicio held high through FIN is accepted again on returning to REPOSO.
- entrada_reg1 always shows the latched operand.

Decomposition:
- Package bcd2bin_pkg holds:
  - state encoding: REPOSO, CARGA, DESPLAZA, CORRIGE, FIN;
  - constants N_DIGITOS=5, N_BITS=16, MAX_BCD=20'h65535;
  - counter width: 5 bits.
- One natural combinational sub-module, corrector_digitos: takes salida_reg and produces carga_a2 and entrada_reg2, built from 5 identical 4-bit >=8 / -3 slices.
- The FSM, counter, operand latch and validity check stay in the top module.

Test Plan:
- Connect the real register model on the falling edge. Apply reset, then bcd_in=20'h00000 with inicio for 1 cycle -> listo at cycle 33, binario=16'h0000, error=0.
- bcd_in=20'h12345 -> binario=16'h3039 at cycle 33. carga_a2 is 0 outside CORRIGE, and desplazar pulses exactly 16 times.
- bcd_in=20'h65535 -> binario=16'hFFFF, error=0. Then bcd_in=20'h65536 -> error=1, binario=0, listo in the cycle after the accept edge, and no reset_carga or desplazar pulses.
- bcd_in=20'h1A000 (invalid digit) -> error=1 with the same 1-cycle listo. A following valid 20'h00099 -> binario=16'h0063, error=0.
- Start 20'h00042, pulse inicio again at cycle 10 with 20'h99999 -> ignored; binario=16'h002A at cycle 33, and only one listo.
- Start 20'h54321, assert reset at cycle 12 -> next cycle: state REPOSO, all outputs 0, ocupado=0. A fresh start with 20'h00007 -> binario=16'h0007.
